// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register with write-back bypass,
// load-use hazard detection and bubble insertion for stalls and flushes.
// Latency: 1 cycle ID -> EX. Stall is combinational from the EX registers and ID inputs.
// Backpressure: on a load-use hazard Stall holds PC/IF-ID upstream for one cycle
// while a bubble enters EX. Flush kills the decode slot and takes priority over Stall.
//
// Ports:
//   clk, rst                      rising-edge clock, synchronous active-high reset
//   IDValid                       decode slot holds a real instruction
//   IDRA1/IDRA2, IDRD1/IDRD2      source addresses and register-file read data
//   IDWA, IDRegWrite, IDMemRead,
//   IDMemWrite, IDALUCtrl, IDImm  decoded destination, controls and immediate
//   WBWE/WBWA/WBWD                write-back port, which is also the RF write port
//   Flush                         branch/jump taken; kill the decode slot
//   Stall                         hold PC and IF/ID (combinational)
//   EX*                           registered EX-stage fields
//   StallCnt/FlushCnt             saturating event counters
module id_ex_stage #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  // decode slot
  input  logic          IDValid,
  input  logic [AW-1:0] IDRA1,
  input  logic [AW-1:0] IDRA2,
  input  logic [DW-1:0] IDRD1,
  input  logic [DW-1:0] IDRD2,
  input  logic [AW-1:0] IDWA,
  input  logic          IDRegWrite,
  input  logic          IDMemRead,
  input  logic          IDMemWrite,
  input  logic [3:0]    IDALUCtrl,
  input  logic [DW-1:0] IDImm,
  // write-back port
  input  logic          WBWE,
  input  logic [AW-1:0] WBWA,
  input  logic [DW-1:0] WBWD,
  // control
  input  logic          Flush,
  output logic          Stall,
  // EX slot
  output logic          EXValid,
  output logic [DW-1:0] EXRD1,
  output logic [DW-1:0] EXRD2,
  output logic [AW-1:0] EXRA1,
  output logic [AW-1:0] EXRA2,
  output logic [AW-1:0] EXWA,
  output logic          EXRegWrite,
  output logic          EXMemRead,
  output logic          EXMemWrite,
  output logic [3:0]    EXALUCtrl,
  output logic [DW-1:0] EXImm,
  // performance counters
  output logic [CW-1:0] StallCnt,
  output logic [CW-1:0] FlushCnt
);

  localparam logic [AW-1:0] ZERO_REG = '0;
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_MAX  = '1;

  // EX-stage registers
  logic          r_ex_valid;
  logic [DW-1:0] r_ex_rd1;
  logic [DW-1:0] r_ex_rd2;
  logic [AW-1:0] r_ex_ra1;
  logic [AW-1:0] r_ex_ra2;
  logic [AW-1:0] r_ex_wa;
  logic          r_ex_regwrite;
  logic          r_ex_memread;
  logic          r_ex_memwrite;
  logic [3:0]    r_ex_aluctrl;
  logic [DW-1:0] r_ex_imm;
  logic [CW-1:0] r_stall_cnt;
  logic [CW-1:0] r_flush_cnt;

  // Operand selection. r0 is hard-wired zero regardless of what the RF or the
  // write-back port say. The bypass covers the case where WB writes the RF on
  // the same edge that this stage captures, since the RF read does not see it.
  logic [DW-1:0] w_op1;
  logic [DW-1:0] w_op2;
  logic          w_byp1;
  logic          w_byp2;

  assign w_byp1 = WBWE && (WBWA == IDRA1) && (WBWA != ZERO_REG);
  assign w_byp2 = WBWE && (WBWA == IDRA2) && (WBWA != ZERO_REG);

  always_comb begin
    w_op1 = IDRD1;
    if (IDRA1 == ZERO_REG) begin
      w_op1 = '0;
    end else if (w_byp1) begin
      w_op1 = WBWD;
    end
  end

  always_comb begin
    w_op2 = IDRD2;
    if (IDRA2 == ZERO_REG) begin
      w_op2 = '0;
    end else if (w_byp2) begin
      w_op2 = WBWD;
    end
  end

  // Load-use hazard: the instruction in EX is a load whose result cannot be
  // forwarded in time to the decoding instruction. A flush already kills the
  // decode slot, so no stall is raised then.
  logic w_src_match;
  logic w_stall;

  assign w_src_match = (r_ex_wa == IDRA1) || (r_ex_wa == IDRA2);
  assign w_stall     = ~Flush & IDValid & r_ex_valid & r_ex_memread &
                       (r_ex_wa != ZERO_REG) & w_src_match;

  // Bubble when the decode slot is killed or held; the stall self-clears on
  // the next cycle because the bubble drops EXValid.
  logic w_bubble;
  assign w_bubble = Flush | w_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_valid    <= 1'b0;
      r_ex_rd1      <= '0;
      r_ex_rd2      <= '0;
      r_ex_ra1      <= '0;
      r_ex_ra2      <= '0;
      r_ex_wa       <= '0;
      r_ex_regwrite <= 1'b0;
      r_ex_memread  <= 1'b0;
      r_ex_memwrite <= 1'b0;
      r_ex_aluctrl  <= '0;
      r_ex_imm      <= '0;
      r_stall_cnt   <= '0;
      r_flush_cnt   <= '0;
    end else begin
      if (w_bubble) begin
        r_ex_valid    <= 1'b0;
        r_ex_rd1      <= '0;
        r_ex_rd2      <= '0;
        r_ex_ra1      <= '0;
        r_ex_ra2      <= '0;
        r_ex_wa       <= '0;
        r_ex_regwrite <= 1'b0;
        r_ex_memread  <= 1'b0;
        r_ex_memwrite <= 1'b0;
        r_ex_aluctrl  <= '0;
        r_ex_imm      <= '0;
      end else begin
        // Controls are qualified by IDValid so an empty slot has no side effects.
        r_ex_valid    <= IDValid;
        r_ex_rd1      <= w_op1;
        r_ex_rd2      <= w_op2;
        r_ex_ra1      <= IDRA1;
        r_ex_ra2      <= IDRA2;
        r_ex_wa       <= IDWA;
        r_ex_regwrite <= IDRegWrite & IDValid;
        r_ex_memread  <= IDMemRead & IDValid;
        r_ex_memwrite <= IDMemWrite & IDValid;
        r_ex_aluctrl  <= IDALUCtrl;
        r_ex_imm      <= IDImm;
      end

      // Flush has priority; w_stall is already zero whenever Flush is high.
      if (Flush && (r_flush_cnt != CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + CNT_ONE;
      end
      if (w_stall && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
    end
  end

  assign Stall      = w_stall;
  assign EXValid    = r_ex_valid;
  assign EXRD1      = r_ex_rd1;
  assign EXRD2      = r_ex_rd2;
  assign EXRA1      = r_ex_ra1;
  assign EXRA2      = r_ex_ra2;
  assign EXWA       = r_ex_wa;
  assign EXRegWrite = r_ex_regwrite;
  assign EXMemRead  = r_ex_memread;
  assign EXMemWrite = r_ex_memwrite;
  assign EXALUCtrl  = r_ex_aluctrl;
  assign EXImm      = r_ex_imm;
  assign StallCnt   = r_stall_cnt;
  assign FlushCnt   = r_flush_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage (built with CW=4 so counter saturation is reachable).
module tb_id_ex_stage;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          IDValid;
  logic [AW-1:0] IDRA1, IDRA2, IDWA;
  logic [DW-1:0] IDRD1, IDRD2, IDImm;
  logic          IDRegWrite, IDMemRead, IDMemWrite;
  logic [3:0]    IDALUCtrl;
  logic          WBWE;
  logic [AW-1:0] WBWA;
  logic [DW-1:0] WBWD;
  logic          Flush;
  logic          Stall;
  logic          EXValid;
  logic [DW-1:0] EXRD1, EXRD2, EXImm;
  logic [AW-1:0] EXRA1, EXRA2, EXWA;
  logic          EXRegWrite, EXMemRead, EXMemWrite;
  logic [3:0]    EXALUCtrl;
  logic [CW-1:0] StallCnt, FlushCnt;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DW(DW), .AW(AW), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .IDValid(IDValid), .IDRA1(IDRA1), .IDRA2(IDRA2), .IDRD1(IDRD1), .IDRD2(IDRD2),
    .IDWA(IDWA), .IDRegWrite(IDRegWrite), .IDMemRead(IDMemRead), .IDMemWrite(IDMemWrite),
    .IDALUCtrl(IDALUCtrl), .IDImm(IDImm),
    .WBWE(WBWE), .WBWA(WBWA), .WBWD(WBWD),
    .Flush(Flush), .Stall(Stall),
    .EXValid(EXValid), .EXRD1(EXRD1), .EXRD2(EXRD2), .EXRA1(EXRA1), .EXRA2(EXRA2),
    .EXWA(EXWA), .EXRegWrite(EXRegWrite), .EXMemRead(EXMemRead), .EXMemWrite(EXMemWrite),
    .EXALUCtrl(EXALUCtrl), .EXImm(EXImm),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one edge and settle 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id_set(input logic v, input logic [AW-1:0] ra1, input logic [DW-1:0] rd1,
                        input logic [AW-1:0] ra2, input logic [DW-1:0] rd2,
                        input logic [AW-1:0] wa, input logic rw, input logic mr,
                        input logic mw, input logic [3:0] alu, input logic [DW-1:0] imm);
    IDValid = v; IDRA1 = ra1; IDRD1 = rd1; IDRA2 = ra2; IDRD2 = rd2; IDWA = wa;
    IDRegWrite = rw; IDMemRead = mr; IDMemWrite = mw; IDALUCtrl = alu; IDImm = imm;
  endtask

  initial begin
    rst = 1'b1; Flush = 1'b0; WBWE = 1'b0; WBWA = '0; WBWD = '0;
    id_set(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 4'h0, '0);
    #1;

    // Reset with random ID traffic
    for (int i = 0; i < 2; i++) begin
      id_set(1'b1, 5'($urandom), $urandom, 5'($urandom), $urandom, 5'($urandom),
             1'b1, 1'b1, 1'b1, 4'($urandom), $urandom);
      tick();
    end
    chk("rst_exvalid", 64'(EXValid), 64'd0);
    chk("rst_exrd1", 64'(EXRD1), 64'd0);
    chk("rst_exrd2", 64'(EXRD2), 64'd0);
    chk("rst_eximm", 64'(EXImm), 64'd0);
    chk("rst_exmemread", 64'(EXMemRead), 64'd0);
    chk("rst_stallcnt", 64'(StallCnt), 64'd0);
    chk("rst_flushcnt", 64'(FlushCnt), 64'd0);
    chk("rst_stall", 64'(Stall), 64'd0);
    rst = 1'b0;

    // Pass-through
    id_set(1'b1, 5'd8, 32'h11111111, 5'd9, 32'h22222222, 5'd3, 1'b1, 1'b0, 1'b0, 4'h5, 32'hFFFFFFFC);
    tick();
    chk("pt_exvalid", 64'(EXValid), 64'd1);
    chk("pt_exrd1", 64'(EXRD1), 64'h11111111);
    chk("pt_exrd2", 64'(EXRD2), 64'h22222222);
    chk("pt_eximm", 64'(EXImm), 64'hFFFFFFFC);
    chk("pt_exra1", 64'(EXRA1), 64'd8);
    chk("pt_exwa", 64'(EXWA), 64'd3);
    chk("pt_exregwrite", 64'(EXRegWrite), 64'd1);
    chk("pt_exalu", 64'(EXALUCtrl), 64'h5);

    // Invalid slot: controls masked
    id_set(1'b0, 5'd8, 32'h33333333, 5'd9, 32'h44444444, 5'd3, 1'b1, 1'b1, 1'b1, 4'h2, 32'h0);
    tick();
    chk("inv_exvalid", 64'(EXValid), 64'd0);
    chk("inv_exregwrite", 64'(EXRegWrite), 64'd0);
    chk("inv_exmemread", 64'(EXMemRead), 64'd0);
    chk("inv_exmemwrite", 64'(EXMemWrite), 64'd0);

    // WB bypass on both ports
    id_set(1'b1, 5'd10, 32'hDEAD0000, 5'd10, 32'hDEAD0001, 5'd4, 1'b1, 1'b0, 1'b0, 4'h1, 32'h0);
    WBWE = 1'b1; WBWA = 5'd10; WBWD = 32'h0000BEEF;
    tick();
    chk("byp_exrd1", 64'(EXRD1), 64'h0000BEEF);
    chk("byp_exrd2", 64'(EXRD2), 64'h0000BEEF);

    // Address match but write-back disabled: RF data wins
    WBWE = 1'b0;
    tick();
    chk("nowe_exrd1", 64'(EXRD1), 64'hDEAD0000);

    // r0 is always zero, even with WB targeting r0
    id_set(1'b1, 5'd0, 32'h12345678, 5'd9, 32'h22222222, 5'd4, 1'b1, 1'b0, 1'b0, 4'h1, 32'h0);
    WBWE = 1'b1; WBWA = 5'd0; WBWD = 32'h0000BEEF;
    tick();
    chk("r0_exrd1", 64'(EXRD1), 64'd0);
    chk("r0_exrd2", 64'(EXRD2), 64'h22222222);
    WBWE = 1'b0;

    // Load-use: lw r12 then add reading r12 on port 2
    id_set(1'b1, 5'd2, 32'h0, 5'd3, 32'h0, 5'd12, 1'b1, 1'b1, 1'b0, 4'h0, 32'h10);
    #1;
    chk("lu_nostall_n", 64'(Stall), 64'd0);
    tick();
    chk("lu_exmemread", 64'(EXMemRead), 64'd1);
    chk("lu_exwa", 64'(EXWA), 64'd12);
    id_set(1'b1, 5'd4, 32'h1, 5'd12, 32'h55, 5'd13, 1'b1, 1'b0, 1'b0, 4'h2, 32'h0);
    #1;
    chk("lu_stall_n1", 64'(Stall), 64'd1);
    tick();
    chk("lu_bubble_valid", 64'(EXValid), 64'd0);
    chk("lu_bubble_memread", 64'(EXMemRead), 64'd0);
    chk("lu_stallcnt", 64'(StallCnt), 64'd1);
    chk("lu_stall_clear", 64'(Stall), 64'd0);
    // Load's value reaches WB on the acceptance edge: bypass applies
    WBWE = 1'b1; WBWA = 5'd12; WBWD = 32'h000000AA;
    tick();
    chk("lu_add_valid", 64'(EXValid), 64'd1);
    chk("lu_add_exra2", 64'(EXRA2), 64'd12);
    chk("lu_add_exwa", 64'(EXWA), 64'd13);
    chk("lu_add_exrd2", 64'(EXRD2), 64'hAA);
    chk("lu_stallcnt_hold", 64'(StallCnt), 64'd1);
    WBWE = 1'b0;

    // Flush beats hazard
    id_set(1'b1, 5'd2, 32'h0, 5'd3, 32'h0, 5'd12, 1'b1, 1'b1, 1'b0, 4'h0, 32'h10);
    tick();
    id_set(1'b1, 5'd4, 32'h1, 5'd12, 32'h55, 5'd13, 1'b1, 1'b0, 1'b0, 4'h2, 32'h7);
    Flush = 1'b1;
    #1;
    chk("fl_stall", 64'(Stall), 64'd0);
    tick();
    Flush = 1'b0;
    chk("fl_exvalid", 64'(EXValid), 64'd0);
    chk("fl_exrd2", 64'(EXRD2), 64'd0);
    chk("fl_eximm", 64'(EXImm), 64'd0);
    chk("fl_exregwrite", 64'(EXRegWrite), 64'd0);
    chk("fl_flushcnt", 64'(FlushCnt), 64'd1);
    chk("fl_stallcnt", 64'(StallCnt), 64'd1);

    // Saturation: lw r12,(r12) held constant stalls every other cycle
    id_set(1'b1, 5'd12, 32'h0, 5'd0, 32'h0, 5'd12, 1'b1, 1'b1, 1'b0, 4'h0, 32'h4);
    for (int i = 0; i < 26; i++) tick();
    chk("sat_cnt14", 64'(StallCnt), 64'd14);
    for (int i = 0; i < 2; i++) tick();
    chk("sat_cnt15", 64'(StallCnt), 64'd15);
    for (int i = 0; i < 12; i++) tick();
    chk("sat_hold15", 64'(StallCnt), 64'd15);
    chk("sat_flushcnt", 64'(FlushCnt), 64'd1);

    // Reset mid-stall
    tick();
    chk("rs_stall_pre", 64'(Stall), 64'd1);
    rst = 1'b1;
    tick();
    chk("rs_exvalid", 64'(EXValid), 64'd0);
    chk("rs_stall", 64'(Stall), 64'd0);
    chk("rs_stallcnt", 64'(StallCnt), 64'd0);
    chk("rs_flushcnt", 64'(FlushCnt), 64'd0);
    chk("rs_exwa", 64'(EXWA), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
